// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared definitions for the program-counter sequencer:
//                sequencer state encoding, instruction step sizes and the
//                default reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Sequencer states. Values are fixed so the encoding is stable across
    // tools and readable in waveforms.
    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        WAIT_TRAP = 2'd2
    } pc_state_e;

    // Byte distance to the next sequential instruction.
    localparam int unsigned INSN_STEP  = 4;
    localparam int unsigned CINSN_STEP = 2;

    // Default boot address; instances truncate it to their own XLEN.
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0040_0000;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_align_check.sv
`default_nettype none
// ============================================================================
//  Module      : pc_align_check
//  Description : Combinational alignment checker for control-flow targets.
//                Reports whether a target satisfies instruction alignment and
//                produces the same address with its alignment bits cleared.
//
//  Ports       : target          in  XLEN  address to check
//                compressed_mode in  1     1: 2-byte alignment, 0: 4-byte
//                aligned         out 1     target already satisfies alignment
//                aligned_addr    out XLEN  target with alignment bits forced 0
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_align_check
    import pc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] target,
    input  logic            compressed_mode,
    output logic            aligned,
    output logic [XLEN-1:0] aligned_addr
);

    // Bit 1 survives only when 2-byte instructions are legal.
    logic w_keep_bit1;

    assign w_keep_bit1  = compressed_mode & target[1];
    assign aligned      = compressed_mode ? ~target[0] : ~(|target[1:0]);
    assign aligned_addr = {target[XLEN-1:2], w_keep_bit1, 1'b0};

endmodule : pc_align_check
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch program-counter sequencer. Holds the fetch PC, steps it
//                under a valid/ready handshake with fetch, and applies trap
//                vectors and branch/jump redirects with fixed priority
//                (trap > redirect > sequential step > stall). A misaligned
//                redirect raises a one-cycle exception pulse and parks the
//                sequencer until the trap handler vector arrives.
//
//  Build option: define SIMPLE_PC_COMPRESSED_EN to add the is_compressed
//                input (2-byte step) and relax alignment to 2 bytes.
//
//  Ports       : clk             in  1     core clock, rising edge
//                rst             in  1     synchronous reset, active low
//                fetch_ready     in  1     fetch accepts pc this cycle
//                is_compressed   in  1     current fetch is 2 bytes (option)
//                pc_valid        out 1     pc is a valid fetch address
//                pc              out XLEN  current fetch PC (registered)
//                pc_plus_step    out XLEN  pc + step, link value
//                redirect_valid  in  1     taken branch/jump this cycle
//                redirect_target in  XLEN  branch/jump target
//                trap_valid      in  1     trap or return this cycle
//                trap_vector     in  XLEN  handler or EPC address
//                misalign_exc    out 1     pulse: redirect target misaligned
//                misalign_addr   out XLEN  offending target, held
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
`ifdef SIMPLE_PC_COMPRESSED_EN
    input  logic            is_compressed,
`endif
    output logic            pc_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_step,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr
);

    localparam logic [XLEN-1:0] c_reset_pc = XLEN'(RESET_PC);

    // ------------------------------------------------------------------
    // Build-dependent step size and alignment mode
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_step;
    logic            w_compressed_mode;

`ifdef SIMPLE_PC_COMPRESSED_EN
    assign w_step            = is_compressed ? XLEN'(CINSN_STEP) : XLEN'(INSN_STEP);
    assign w_compressed_mode = 1'b1;
`else
    assign w_step            = XLEN'(INSN_STEP);
    assign w_compressed_mode = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    pc_state_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_misalign_exc;
    logic [XLEN-1:0] r_misalign_addr;

    pc_state_e       w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_exc_nxt;
    logic [XLEN-1:0] w_addr_nxt;

    // ------------------------------------------------------------------
    // Shared alignment checker. Trap has priority over redirect, so the
    // trap vector is checked whenever a trap is present; a redirect that
    // loses to a trap is never examined.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_chk_target;
    logic            w_chk_aligned;
    logic [XLEN-1:0] w_chk_addr;

    assign w_chk_target = trap_valid ? trap_vector : redirect_target;

    pc_align_check #(
        .XLEN            (XLEN)
    ) u_align_check (
        .target          (w_chk_target),
        .compressed_mode (w_compressed_mode),
        .aligned         (w_chk_aligned),
        .aligned_addr    (w_chk_addr)
    );

    // Link value wraps modulo 2^XLEN by construction of the adder width.
    assign pc_plus_step = r_pc + w_step;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (!trap_valid && redirect_valid && !w_chk_aligned) begin
                    w_state_nxt = WAIT_TRAP;
                end
            end
            WAIT_TRAP: begin
                if (trap_valid) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_valid = 1'b0;
        case (r_state)
            RUN:     pc_valid = 1'b1;
            default: pc_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // PC / exception datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_nxt   = r_pc;
        w_exc_nxt  = 1'b0;          // exception is a single-cycle pulse
        w_addr_nxt = r_misalign_addr;
        case (r_state)
            BOOT, WAIT_TRAP: begin
                // Redirects and fetch handshakes are ignored here; only a
                // trap vector may move the PC.
                if (trap_valid) begin
                    w_pc_nxt = w_chk_addr;
                end
            end
            RUN: begin
                if (trap_valid) begin
                    w_pc_nxt = w_chk_addr;
                end else if (redirect_valid) begin
                    if (w_chk_aligned) begin
                        // Flush semantics: taken regardless of fetch_ready.
                        w_pc_nxt = w_chk_addr;
                    end else begin
                        w_exc_nxt  = 1'b1;
                        w_addr_nxt = redirect_target;
                    end
                end else if (fetch_ready) begin
                    w_pc_nxt = pc_plus_step;
                end
            end
            default: begin
                w_pc_nxt = r_pc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc            <= c_reset_pc;
            r_misalign_exc  <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_pc            <= w_pc_nxt;
            r_misalign_exc  <= w_exc_nxt;
            r_misalign_addr <= w_addr_nxt;
        end
    end

    assign pc            = r_pc;
    assign misalign_exc  = r_misalign_exc;
    assign misalign_addr = r_misalign_addr;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. A driver issues
//                directed and random stimulus, advances a behavioural model
//                and queues the expected outputs; a monitor pops and compares
//                them one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int XLEN = 64;
`ifdef SIMPLE_PC_COMPRESSED_EN
    localparam logic [63:0] ALIGN = 64'd2;
`else
    localparam logic [63:0] ALIGN = 64'd4;
`endif
    localparam logic [63:0] BOOT_PC = 64'h0000_0000_0040_0000;

    typedef struct {
        logic        valid;
        logic [63:0] pc;
        logic        exc;
        logic [63:0] addr;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            fetch_ready;
    logic            is_c;
    logic            pc_valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_step;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_valid;
    logic [XLEN-1:0] trap_vector;
    logic            misalign_exc;
    logic [XLEN-1:0] misalign_addr;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: the PC, whether we are in the boot bubble, whether we are
    // parked awaiting a trap, plus the exception outputs.
    logic [63:0] m_pc;
    bit          m_booting;
    bit          m_parked;
    logic        m_exc;
    logic [63:0] m_addr;

    always #5 clk = ~clk;

    pc_sequencer #(
        .XLEN            (XLEN),
        .RESET_PC        (BOOT_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_ready     (fetch_ready),
`ifdef SIMPLE_PC_COMPRESSED_EN
        .is_compressed   (is_c),
`endif
        .pc_valid        (pc_valid),
        .pc              (pc),
        .pc_plus_step    (pc_plus_step),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .misalign_exc    (misalign_exc),
        .misalign_addr   (misalign_addr)
    );

    function automatic logic [63:0] step_of(input logic c);
`ifdef SIMPLE_PC_COMPRESSED_EN
        return c ? 64'd2 : 64'd4;
`else
        return (c === 1'bx) ? 64'd4 : 64'd4;
`endif
    endfunction

    function automatic logic [63:0] round_down(input logic [63:0] v);
        return v - (v % ALIGN);
    endfunction

    // Apply one cycle of inputs, advance the model, queue what the DUT
    // should show after the next rising edge, then wait for the falling edge.
    task automatic cycle(input bit r, input bit fr, input bit rv,
                         input logic [63:0] rt, input bit tv,
                         input logic [63:0] tvec, input bit c);
        exp_t e;
        rst = r; fetch_ready = fr; redirect_valid = rv;
        redirect_target = rt; trap_valid = tv; trap_vector = tvec; is_c = c;

        if (!r) begin
            m_pc = BOOT_PC; m_booting = 1; m_parked = 0;
            m_exc = 0; m_addr = 64'd0;
        end else if (m_booting) begin
            m_booting = 0; m_exc = 0;
            if (tv) m_pc = round_down(tvec);
        end else if (m_parked) begin
            m_exc = 0;
            if (tv) begin
                m_pc = round_down(tvec);
                m_parked = 0;
            end
        end else begin
            m_exc = 0;
            if (tv) begin
                m_pc = round_down(tvec);
            end else if (rv) begin
                if (rt % ALIGN == 64'd0) begin
                    m_pc = rt;
                end else begin
                    m_exc = 1; m_addr = rt; m_parked = 1;
                end
            end else if (fr) begin
                m_pc = m_pc + step_of(c);
            end
        end

        e.valid = !m_booting && !m_parked;
        e.pc    = m_pc;
        e.exc   = m_exc;
        e.addr  = m_addr;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check1(input string name, input logic [63:0] act,
                          input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected record per rising edge, compared 1 ns later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check1("pc_valid",      {63'd0, pc_valid},     {63'd0, e.valid});
                check1("pc",            pc,                    e.pc);
                check1("pc_plus_step",  pc_plus_step,          e.pc + step_of(is_c));
                check1("misalign_exc",  {63'd0, misalign_exc}, {63'd0, e.exc});
                check1("misalign_addr", misalign_addr,         e.addr);
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] t;
        logic [63:0] v;
        // Reset
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        // Boot bubble then sequential stepping
        repeat (4) cycle(1, 1, 0, 0, 0, 0, 0);
        // Stall and flush redirect with fetch_ready low
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 64'h400100, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        // Misaligned redirect (base build), ignored redirect, trap out
        cycle(1, 1, 1, 64'h400102, 0, 0, 0);
        cycle(1, 1, 1, 64'h500000, 0, 0, 0);
        cycle(1, 1, 1, 64'h500001, 0, 0, 0);
        cycle(1, 1, 0, 0, 1, 64'h80000003, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        // Trap wins over simultaneous redirect
        cycle(1, 1, 1, 64'h2000, 1, 64'h1000, 0);
        cycle(1, 0, 1, 64'h2001, 1, 64'h1002, 0);
        // Wraparound
        cycle(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        // Trap during boot bubble, redirect in boot ignored
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 64'h3000, 1, 64'h7777, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 64'h3000, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
`ifdef SIMPLE_PC_COMPRESSED_EN
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 1);
        cycle(1, 0, 1, 64'h400006, 0, 0, 0);
        cycle(1, 0, 1, 64'h400007, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
`else
        cycle(1, 0, 1, 64'h400007, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
`endif
        // Reset while parked
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            t = {$urandom, $urandom};
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            v = {$urandom, $urandom};
            cycle($urandom_range(49) != 0,
                  $urandom_range(9) < 7,
                  $urandom_range(4) == 0, t,
                  $urandom_range(7) == 0, v,
                  $urandom_range(1) == 1);
        end

        // Drain
        for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
